// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_NREG     = 32;
  localparam int DEF_ZERO_REG = 31;

  // Address width for n registers, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write port, read ports and status of the register file, bundled for the top level.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int NRD   = 2
);
  localparam int AW = addr_w(NREG);

  logic                          we3;
  logic [AW-1:0]                 wa3;
  logic [WIDTH-1:0]              wd3;
  logic [NRD-1:0][AW-1:0]        ra;
  logic [NRD-1:0][WIDTH-1:0]     rd;
  logic                          init_busy;

  modport master (output we3, wa3, wd3, ra, input rd, init_busy);
  modport slave  (input we3, wa3, wd3, ra, output rd, init_busy);

endinterface

// File: rtl/regfile_init_seq.sv
// INIT/READY sequencer: after reset it walks every index once, loading reg[i] = i.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREG     = DEF_NREG,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int AW       = addr_w(DEF_NREG)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_busy,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [WIDTH-1:0] init_data
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (int'(cnt_q) == NREG - 1) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // Busy also covers the reset cycles themselves so reads are blanked immediately.
  always_comb begin
    init_busy = reset || (state_q == INIT);
    init_we   = !reset && (state_q == INIT) &&
                (int'(cnt_q) != ZERO_REG) && (int'(cnt_q) < NREG);
    init_addr = cnt_q;
    init_data = WIDTH'(cnt_q);
  end

endmodule

// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with hard-wired zero register,
// optional write-to-read bypass and a self-initialising INIT sequence.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = 2,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = 1
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);

  localparam int AW = addr_w(NREG);

  // Zero register and indices beyond NREG are neither writable nor readable.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) != ZERO_REG) && (int'(a) < NREG);
  endfunction

  logic             init_busy;
  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] init_data;

  regfile_init_seq #(
    .WIDTH    (WIDTH),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  logic                      user_we;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [WIDTH-1:0]          regs_q [NREG];
  logic [WIDTH-1:0]          regs_d [NREG];
  logic [NRD-1:0][WIDTH-1:0] rd_mux;

  // The sequencer owns the write port for the whole INIT phase.
  always_comb begin
    user_we = !init_busy && bus.we3 && addr_ok(bus.wa3);
    wr_en   = init_we || user_we;
    wr_addr = init_busy ? init_addr : bus.wa3;
    wr_data = init_busy ? init_data : bus.wd3;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Storage carries no reset; contents are rebuilt by the INIT walk.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_mux[p] = '0;
      if (!init_busy && addr_ok(bus.ra[p])) begin
        if ((BYPASS != 0) && user_we && (bus.wa3 == bus.ra[p])) begin
          rd_mux[p] = bus.wd3;
        end else begin
          rd_mux[p] = regs_q[bus.ra[p]];
        end
      end
    end
  end

  assign bus.rd        = rd_mux;
  assign bus.init_busy = init_busy;

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 64: data width of every register and port in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers, range 2..32.
REQ-003 Parameter NRD, default 2: number of independent read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 31: index of the hard-wired zero register (XZR).
REQ-005 Parameter BYPASS, default 1: 1 forwards the same-cycle write to the read ports; 0 returns the stored value.
REQ-006 Derived constant AW = clog2(NREG), minimum 1: address width.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 we3  input  1  write enable.
REQ-010 wa3  input  AW  write address.
REQ-011 wd3  input  WIDTH  write data.
REQ-012 ra  input  NRD x AW  read addresses, one per port.
REQ-013 rd  output  NRD x WIDTH  read data, one per port, combinational from ra.
REQ-014 init_busy  output  1  high while the initialisation sequence runs.

Function
REQ-015 Two-state FSM: INIT and READY.
- reset=1 at an edge -> INIT with cnt=0, regardless of current state.
- In INIT, each edge with reset=0 writes reg[cnt] = cnt zero-extended to WIDTH, then increments cnt.
- Exception: ZERO_REG and any index >= NREG are not written.
- At the edge that handles cnt = NREG-1 -> READY.
REQ-016 INIT therefore lasts exactly NREG edges after reset is released; init_busy = (state == INIT).
REQ-017 In INIT, we3 is ignored and every rd port returns 0.
REQ-018 In READY, an edge with we3=1, wa3 != ZERO_REG and wa3 < NREG writes reg[wa3] = wd3.
- Writes to ZERO_REG or an out-of-range address are discarded silently.
REQ-019 Reads in READY:
- ra[p] == ZERO_REG or ra[p] >= NREG -> rd[p] = 0.
- Otherwise rd[p] = reg[ra[p]], with zero-cycle latency.
REQ-020 With BYPASS=1 in READY: if we3=1, wa3 == ra[p] and the write is legal per REQ-018, rd[p] = wd3 in the same cycle.
REQ-021 With BYPASS=0, a read of the address being written returns the old value until after the edge.
REQ-022 All NRD ports are independent; any number of ports may read the same address at once, including the write address, with identical results.
REQ-023 Registers hold their value indefinitely in READY while they are not written; there is no other side effect.

Reset
REQ-024 Reset restarts the sequence at cnt=0 even when asserted mid-INIT.
REQ-025 Register contents are not cleared by reset itself; they are rewritten only by the INIT sequence.
REQ-026 While reset=1: init_busy=1 and all rd = 0.
REQ-027 After INIT completes, reg[i] = i for every i < NREG with i != ZERO_REG, and ZERO_REG reads 0.

Structure
REQ-028 Shared package regfile_pkg holds:
- the state enum rf_state_t {INIT, READY};
- default parameter constants for WIDTH, NREG and ZERO_REG.
REQ-029 Sub-module regfile_init_seq holds the FSM and counter.
- Outputs: init_busy, init_we, init_addr, init_data.
- regfile_param muxes these onto the storage write port.
REQ-030 Storage is a flop array updated only in one clocked process.

Verification
REQ-031 Reset released at cycle 0 (NREG=32): init_busy=1 for 32 edges, then 0; ra={5,31} -> rd={5,0}; ra={30,0} -> rd={30,0}.
REQ-032 READY, we3=1, wa3=7, wd3=64'hDEAD_BEEF, ra={7,7}: BYPASS=1 -> rd={DEAD_BEEF,DEAD_BEEF} same cycle; BYPASS=0 -> rd={7,7}, then DEAD_BEEF after the edge.
REQ-033 READY, we3=1, wa3=31, wd3=64'hFFFF: after the edge ra=31 -> rd=0, with no bypass in the write cycle.
REQ-034 Reset pulsed at INIT cycle 10: init_busy stays high for 32 more edges; we3=1 with wa3=3 during INIT has no effect, so reg3 reads 3 afterwards.
REQ-035 NREG=24, ZERO_REG=23, AW=5, READY: write wa3=27 is ignored; ra=27 -> rd=0; ra=22 -> rd=22.
REQ-036 NRD=4, WIDTH=32: four ports read {1,2,3,1} -> {1,2,3,1}; random writes and reads versus a reference model over 10k cycles with zero mismatches.
